matrix_cmd_sequencer: RTL and testbench

//  Multi-byte UART command parser and sequencer for the LED matrix. Consumes bytes from uart_rx,

---
 rtl/matrix_cmd_pkg.sv | 30 +++
 rtl/matrix_fb_writer.sv | 55 +++++
 rtl/matrix_cmd_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_matrix_cmd_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_cmd_pkg.sv
// Shared opcodes, parser state encoding and pixel layout for the LED matrix command path.
package matrix_cmd_pkg;

    localparam logic [7:0] OP_R_SET = 8'h52;  // 'R'
    localparam logic [7:0] OP_R_CLR = 8'h72;  // 'r'
    localparam logic [7:0] OP_G_SET = 8'h47;  // 'G'
    localparam logic [7:0] OP_G_CLR = 8'h67;  // 'g'
    localparam logic [7:0] OP_B_SET = 8'h42;  // 'B'
    localparam logic [7:0] OP_B_CLR = 8'h62;  // 'b'
    localparam logic [7:0] OP_LEVEL = 8'h4C;  // 'L'
    localparam logic [7:0] OP_PIXEL = 8'h50;  // 'P'
    localparam logic [7:0] OP_FILL  = 8'h46;  // 'F'
    localparam logic [7:0] OP_CLEAR = 8'h43;  // 'C'

    // ~10 ms at 53.2 MHz; only used when CMD_TIMEOUT_EN is defined
    localparam int TIMEOUT_CYCLES = 532000;
    localparam int TIMEOUT_WIDTH  = 20;

    typedef enum logic [3:0] {
        S_IDLE, S_ARG_BRIGHT, S_ADDR_HI, S_ADDR_LO, S_COUNT,
        S_PIX_R, S_PIX_G, S_PIX_B, S_CLEAR
    } state_e;

    typedef struct packed {
        logic [7:0] b;
        logic [7:0] g;
        logic [7:0] r;
    } pixel_t;

endpackage

// File: rtl/matrix_fb_writer.sv
// Single-entry frame buffer write slot: holds one request until fb_wr_ready accepts it.
module matrix_fb_writer
    import matrix_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  pixel_t                req_data,
    output logic                  pending,
    input  logic                  fb_wr_ready,
    output logic                  fb_wr_en,
    output logic [ADDR_WIDTH-1:0] fb_wr_addr,
    output logic [23:0]           fb_wr_data
);

    logic                  en_q, en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    pixel_t                data_q, data_d;

    // A slot retiring this cycle can be refilled in the same cycle
    assign pending = en_q && !fb_wr_ready;

    always_comb begin
        en_d   = en_q;
        addr_d = addr_q;
        data_d = data_q;
        if (req_valid && !pending) begin
            en_d   = 1'b1;
            addr_d = req_addr;
            data_d = req_data;
        end else if (en_q && fb_wr_ready) begin
            en_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            en_q   <= en_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign fb_wr_en   = en_q;
    assign fb_wr_addr = addr_q;
    assign fb_wr_data = data_q;

endmodule

// File: rtl/matrix_cmd_sequencer.sv
// UART byte-stream command parser driving LED matrix config and frame buffer writes.
// Optional CMD_TIMEOUT_EN aborts partial commands after TIMEOUT_CYCLES idle cycles.
module matrix_cmd_sequencer
    import matrix_cmd_pkg::*;
#(
    parameter int PIXEL_COUNT  = 2048,
    parameter int ADDR_WIDTH   = 11,
    parameter int BRIGHT_WIDTH = 4
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    input  logic                    rx_invalid,
    output logic [2:0]              rgb_enable,
    output logic [BRIGHT_WIDTH-1:0] brightness,
    output logic                    fb_wr_en,
    input  logic                    fb_wr_ready,
    output logic [ADDR_WIDTH-1:0]   fb_wr_addr,
    output logic [23:0]             fb_wr_data,
    output logic                    busy,
    output logic                    cmd_error
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIXEL_COUNT - 1);
    localparam logic [16:0]           PIX_LIMIT = 17'(PIXEL_COUNT);

    state_e                  state_q, state_d;
    logic                    fill_q, fill_d;
    logic [7:0]              addr_hi_q, addr_hi_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    addr_bad_q, addr_bad_d;
    logic [8:0]              count_q, count_d;
    logic [7:0]              pix_r_q, pix_r_d, pix_g_q, pix_g_d;
    logic [2:0]              rgb_q, rgb_d;
    logic [BRIGHT_WIDTH-1:0] bright_q, bright_d;
    logic                    err_q, err_d;

    logic                    req_valid, wr_pending;
    logic [ADDR_WIDTH-1:0]   req_addr;
    pixel_t                  req_data;
    logic [15:0]             full_addr;

`ifdef CMD_TIMEOUT_EN
    logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d;
`endif

    assign full_addr = {addr_hi_q, rx_data};

    always_comb begin
        state_d    = state_q;
        fill_d     = fill_q;
        addr_hi_d  = addr_hi_q;
        addr_d     = addr_q;
        addr_bad_d = addr_bad_q;
        count_d    = count_q;
        pix_r_d    = pix_r_q;
        pix_g_d    = pix_g_q;
        rgb_d      = rgb_q;
        bright_d   = bright_q;
        err_d      = 1'b0;
        req_valid  = 1'b0;
        req_addr   = addr_q;
        req_data   = '{b: rx_data, g: pix_g_q, r: pix_r_q};

        if (state_q == S_CLEAR) begin
            // Clear owns the write slot; every incoming byte is a protocol error
            req_valid = 1'b1;
            req_data  = '0;
            if (!wr_pending) begin
                addr_d = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                if (addr_q == LAST_ADDR) state_d = S_IDLE;
            end
            if (rx_valid) err_d = 1'b1;
        end else if (rx_valid && rx_invalid) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
        end else if (rx_valid) begin
            case (state_q)
                S_IDLE: begin
                    case (rx_data)
                        OP_R_SET: rgb_d[0] = 1'b1;
                        OP_R_CLR: rgb_d[0] = 1'b0;
                        OP_G_SET: rgb_d[1] = 1'b1;
                        OP_G_CLR: rgb_d[1] = 1'b0;
                        OP_B_SET: rgb_d[2] = 1'b1;
                        OP_B_CLR: rgb_d[2] = 1'b0;
                        OP_LEVEL: state_d = S_ARG_BRIGHT;
                        OP_PIXEL: begin fill_d = 1'b0; state_d = S_ADDR_HI; end
                        OP_FILL:  begin fill_d = 1'b1; state_d = S_ADDR_HI; end
                        OP_CLEAR: begin addr_d = '0; state_d = S_CLEAR; end
                        default:  err_d = 1'b1;
                    endcase
                end
                S_ARG_BRIGHT: begin
                    bright_d = rx_data[BRIGHT_WIDTH-1:0];
                    state_d  = S_IDLE;
                end
                S_ADDR_HI: begin
                    addr_hi_d = rx_data;
                    state_d   = S_ADDR_LO;
                end
                S_ADDR_LO: begin
                    addr_d     = full_addr[ADDR_WIDTH-1:0];
                    addr_bad_d = {1'b0, full_addr} >= PIX_LIMIT;
                    err_d      = addr_bad_d;
                    count_d    = 9'd1;
                    state_d    = fill_q ? S_COUNT : S_PIX_R;
                end
                S_COUNT: begin
                    count_d = (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
                    state_d = S_PIX_R;
                end
                S_PIX_R: begin pix_r_d = rx_data; state_d = S_PIX_G; end
                S_PIX_G: begin pix_g_d = rx_data; state_d = S_PIX_B; end
                S_PIX_B: begin
                    if (!addr_bad_q) begin
                        if (wr_pending) err_d = 1'b1;
                        else            req_valid = 1'b1;
                    end
                    addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    count_d = count_q - 9'd1;
                    state_d = (count_q == 9'd1) ? S_IDLE : S_PIX_R;
                end
                default: state_d = S_IDLE;
            endcase
        end

`ifdef CMD_TIMEOUT_EN
        tmo_d = '0;
        if (!rx_valid && state_q != S_IDLE && state_q != S_CLEAR) begin
            if (tmo_q == TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                err_d   = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fill_q     <= 1'b0;
            addr_hi_q  <= '0;
            addr_q     <= '0;
            addr_bad_q <= 1'b0;
            count_q    <= '0;
            pix_r_q    <= '0;
            pix_g_q    <= '0;
            rgb_q      <= 3'b111;
            bright_q   <= '1;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            fill_q     <= fill_d;
            addr_hi_q  <= addr_hi_d;
            addr_q     <= addr_d;
            addr_bad_q <= addr_bad_d;
            count_q    <= count_d;
            pix_r_q    <= pix_r_d;
            pix_g_q    <= pix_g_d;
            rgb_q      <= rgb_d;
            bright_q   <= bright_d;
            err_q      <= err_d;
        end
    end

`ifdef CMD_TIMEOUT_EN
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`endif

    matrix_fb_writer #(.ADDR_WIDTH(ADDR_WIDTH)) u_writer (
        .clk_in      (clk_in),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .pending     (wr_pending),
        .fb_wr_ready (fb_wr_ready),
        .fb_wr_en    (fb_wr_en),
        .fb_wr_addr  (fb_wr_addr),
        .fb_wr_data  (fb_wr_data)
    );

    assign rgb_enable = rgb_q;
    assign brightness = bright_q;
    assign cmd_error  = err_q;
    assign busy       = (state_q != S_IDLE) || fb_wr_en;

endmodule

// File: tb/tb_matrix_cmd_sequencer.sv
// Directed bench for matrix_cmd_sequencer: config commands, pixel/burst/clear writes, error paths.
module tb_matrix_cmd_sequencer;

    logic        clk_in = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid, rx_invalid;
    logic [2:0]  rgb_enable;
    logic [3:0]  brightness;
    logic        fb_wr_en, fb_wr_ready;
    logic [10:0] fb_wr_addr;
    logic [23:0] fb_wr_data;
    logic        busy, cmd_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [10:0] log_addr[$];
    logic [23:0] log_data[$];

    matrix_cmd_sequencer dut (
        .clk_in(clk_in), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_invalid(rx_invalid), .rgb_enable(rgb_enable), .brightness(brightness),
        .fb_wr_en(fb_wr_en), .fb_wr_ready(fb_wr_ready), .fb_wr_addr(fb_wr_addr),
        .fb_wr_data(fb_wr_data), .busy(busy), .cmd_error(cmd_error)
    );

    always #5 clk_in = ~clk_in;

    // Record every retired write (sampled at the retiring edge)
    always @(posedge clk_in) begin
        if (!reset && fb_wr_en && fb_wr_ready) begin
            log_addr.push_back(fb_wr_addr);
            log_data.push_back(fb_wr_data);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the byte has been sampled
    task automatic send_byte(input logic [7:0] b, input logic inv);
        rx_data = b; rx_valid = 1'b1; rx_invalid = inv;
        @(posedge clk_in); #1;
        rx_valid = 1'b0; rx_invalid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_invalid = 1'b0; fb_wr_ready = 1'b0;
        repeat (2) @(posedge clk_in); #1;
        n_checks++;
        if ({rgb_enable, brightness, fb_wr_en, fb_wr_addr, fb_wr_data, busy, cmd_error} !==
            {3'b111, 4'hF, 1'b0, 11'd0, 24'd0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset: rgb=%b br=%h en=%b addr=%0d data=%h busy=%b err=%b", rgb_enable,
                     brightness, fb_wr_en, fb_wr_addr, fb_wr_data, busy, cmd_error);
        end
        reset = 1'b0;
        @(posedge clk_in); #1;
    endtask

    task automatic test_rgb();
        send_byte(8'h72, 1'b0);  // 'r'
        n_checks++;
        if (rgb_enable !== 3'b110) begin n_fail++; $display("FAIL rgb_r: got %b want 110", rgb_enable); end
        send_byte(8'h42, 1'b0);  // 'B'
        n_checks++;
        if (rgb_enable !== 3'b110) begin n_fail++; $display("FAIL rgb_B: got %b want 110", rgb_enable); end
        send_byte(8'h62, 1'b0);  // 'b'
        n_checks++;
        if (rgb_enable !== 3'b010) begin n_fail++; $display("FAIL rgb_b: got %b want 010", rgb_enable); end
    endtask

    task automatic test_brightness();
        send_byte(8'h4C, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL bright_busy_arg: got %b want 1", busy); end
        send_byte(8'h35, 1'b0);
        n_checks++;
        if (brightness !== 4'h5) begin n_fail++; $display("FAIL bright_val: got %h want 5", brightness); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL bright_busy_done: got %b want 0", busy); end
    endtask

    task automatic test_pixel();
        logic [7:0] cmd [6];
        cmd = '{8'h50, 8'h00, 8'h05, 8'h11, 8'h22, 8'h33};
        log_addr.delete(); log_data.delete();
        fb_wr_ready = 1'b0;
        foreach (cmd[i]) send_byte(cmd[i], 1'b0);
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if ({fb_wr_en, fb_wr_addr, fb_wr_data} !== {1'b1, 11'd5, 24'h332211}) begin
                n_fail++;
                $display("FAIL pixel_hold[%0d]: en=%b addr=%0d data=%h want 1/5/332211", c, fb_wr_en,
                         fb_wr_addr, fb_wr_data);
            end
            @(posedge clk_in); #1;
        end
        fb_wr_ready = 1'b1;
        @(posedge clk_in); #1;
        n_checks++;
        if (fb_wr_en !== 1'b0) begin n_fail++; $display("FAIL pixel_release: en=%b want 0", fb_wr_en); end
        n_checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 11'd5 || log_data[0] !== 24'h332211) begin
            n_fail++;
            $display("FAIL pixel_log: writes=%0d want 1 at 5/332211", log_addr.size());
        end
    endtask

    task automatic test_burst();
        logic [7:0]  cmd [13];
        logic [10:0] exp_a [3];
        logic [23:0] exp_d [3];
        cmd   = '{8'h46, 8'h07, 8'hFE, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
                  8'h77, 8'h88, 8'h99};
        exp_a = '{11'd2046, 11'd2047, 11'd0};
        exp_d = '{24'h332211, 24'h665544, 24'h998877};
        log_addr.delete(); log_data.delete();
        fb_wr_ready = 1'b1;
        foreach (cmd[i]) send_byte(cmd[i], 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL burst_busy_last: got %b want 1", busy); end
        @(posedge clk_in); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_busy_after: got %b want 0", busy); end
        n_checks++;
        if (log_addr.size() != 3) begin
            n_fail++; $display("FAIL burst_count: got %0d want 3", log_addr.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                n_checks++;
                if (log_addr[k] !== exp_a[k] || log_data[k] !== exp_d[k]) begin
                    n_fail++;
                    $display("FAIL burst_write[%0d]: got %0d/%h want %0d/%h", k, log_addr[k],
                             log_data[k], exp_a[k], exp_d[k]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        logic [7:0] cmd [12];
        cmd = '{8'h50, 8'h00, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'h50, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03};
        log_addr.delete(); log_data.delete();
        fb_wr_ready = 1'b0;
        foreach (cmd[i]) send_byte(cmd[i], 1'b0);
        n_checks++;
        if (cmd_error !== 1'b1) begin n_fail++; $display("FAIL overrun_err: got %b want 1", cmd_error); end
        n_checks++;
        if (fb_wr_addr !== 11'd1 || fb_wr_data !== 24'hCCBBAA) begin
            n_fail++;
            $display("FAIL overrun_hold: got %0d/%h want 1/ccbbaa", fb_wr_addr, fb_wr_data);
        end
        fb_wr_ready = 1'b1;
        repeat (2) @(posedge clk_in); #1;
        n_checks++;
        if (log_addr.size() != 1 || log_addr[0] !== 11'd1) begin
            n_fail++; $display("FAIL overrun_log: writes=%0d want 1 at addr 1", log_addr.size());
        end
    endtask

    task automatic test_clear();
        int bad = 0;
        bit done = 0;
        log_addr.delete(); log_data.delete();
        fb_wr_ready = 1'b0;
        send_byte(8'h43, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy: got %b want 1", busy); end
        for (int i = 0; i < 20000 && !done; i++) begin
            fb_wr_ready = i[0];
            if (i == 100) begin rx_data = 8'h52; rx_valid = 1'b1; end
            @(posedge clk_in); #1;
            rx_valid = 1'b0;
            if (i == 100) begin
                n_checks++;
                if (cmd_error !== 1'b1) begin
                    n_fail++; $display("FAIL clear_byte_err: got %b want 1", cmd_error);
                end
            end
            if (!busy) done = 1;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL clear_timeout: busy=%b want 0", busy); end
        n_checks++;
        if (rgb_enable !== 3'b010) begin n_fail++; $display("FAIL clear_rgb: got %b want 010", rgb_enable); end
        n_checks++;
        if (log_addr.size() != 2048) begin
            n_fail++; $display("FAIL clear_count: got %0d want 2048", log_addr.size());
        end
        foreach (log_addr[k]) if (log_addr[k] !== 11'(k) || log_data[k] !== 24'd0) bad++;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL clear_order: %0d bad entries want 0", bad); end
    endtask

    task automatic test_bad_addr();
        logic [7:0] cmd [3];
        cmd = '{8'h11, 8'h22, 8'h33};
        log_addr.delete(); log_data.delete();
        fb_wr_ready = 1'b1;
        send_byte(8'h50, 1'b0);
        send_byte(8'h09, 1'b0);
        send_byte(8'h00, 1'b0);
        n_checks++;
        if (cmd_error !== 1'b1) begin n_fail++; $display("FAIL badaddr_err: got %b want 1", cmd_error); end
        foreach (cmd[i]) send_byte(cmd[i], 1'b0);
        @(posedge clk_in); #1;
        n_checks++;
        if (log_addr.size() != 0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL badaddr_nowrite: writes=%0d busy=%b want 0/0", log_addr.size(), busy);
        end
    endtask

    task automatic test_invalid();
        send_byte(8'h46, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h55, 1'b1);
        n_checks++;
        if (cmd_error !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL invalid_abort: err=%b busy=%b want 1/0", cmd_error, busy);
        end
        send_byte(8'h67, 1'b0);  // 'g' must decode as a fresh command
        n_checks++;
        if (rgb_enable !== 3'b000) begin n_fail++; $display("FAIL invalid_next: got %b want 000", rgb_enable); end
        send_byte(8'h58, 1'b0);  // unknown opcode
        n_checks++;
        if (cmd_error !== 1'b1 || busy !== 1'b0 || rgb_enable !== 3'b000) begin
            n_fail++;
            $display("FAIL unknown_op: err=%b busy=%b rgb=%b want 1/0/000", cmd_error, busy, rgb_enable);
        end
        @(posedge clk_in); #1;
        n_checks++;
        if (cmd_error !== 1'b0) begin n_fail++; $display("FAIL err_pulse: got %b want 0", cmd_error); end
    endtask

    task automatic test_reset_mid_clear();
        int snap;
        fb_wr_ready = 1'b1;
        send_byte(8'h43, 1'b0);
        repeat (20) @(posedge clk_in); #1;
        reset = 1'b1;
        #1;
        snap = log_addr.size();
        n_checks++;
        if (fb_wr_en !== 1'b0 || busy !== 1'b0 || rgb_enable !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_mid: en=%b busy=%b rgb=%b want 0/0/111", fb_wr_en, busy, rgb_enable);
        end
        @(posedge clk_in); #1;
        reset = 1'b0;
        repeat (10) @(posedge clk_in); #1;
        n_checks++;
        if (log_addr.size() != snap || busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid_idle: writes=%0d want %0d busy=%b", log_addr.size(), snap, busy);
        end
    endtask

    initial begin
        test_reset();
        test_rgb();
        test_brightness();
        test_pixel();
        test_burst();
        test_overrun();
        test_clear();
        test_bad_addr();
        test_invalid();
        test_reset_mid_clear();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
